// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param_if
// Brief    : Producer/consumer signal bundle for sync_fifo_param.
// Revision : 1.0
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock parametrised FIFO with thresholds, FWFT and errors.
// Revision : 1.0
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_TH      = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst_n,
    sync_fifo_param_if.slave  fifo
);
    localparam int                  c_depth    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth_w  = (ADDR_WIDTH + 1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_af_th    = (ADDR_WIDTH + 1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] c_ae_th    = (ADDR_WIDTH + 1)'(AE_TH);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags come from the count register only, never from the request inputs.
    assign w_full   = (r_count == c_depth_w);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = fifo.rd_en & ~w_empty;
    assign w_wr_acc = fifo.wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= fifo.wr_en & ~w_wr_acc;
            r_underflow <= fifo.rd_en & ~w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= fifo.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign fifo.rd_data = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign fifo.rd_data = r_rd_data;
        end
    endgenerate

    assign fifo.full         = w_full;
    assign fifo.empty        = w_empty;
    assign fifo.almost_full  = (r_count >= c_af_th);
    assign fifo.almost_empty = (r_count <= c_ae_th);
    assign fifo.data_count   = r_count;
    assign fifo.overflow     = r_overflow;
    assign fifo.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Scoreboard bench for sync_fifo_param (standard and FWFT builds).
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_param;
    logic clk;
    logic rst_n;

    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

    sync_fifo_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_TH(14), .AE_TH(2), .FWFT(0)
    ) u_dut0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .fifo      (bus0)
    );

    sync_fifo_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_TH(14), .AE_TH(2), .FWFT(1)
    ) u_dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .fifo      (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_q[$];     // model contents
    logic [7:0] exp_q[$];   // words the consumer is owed
    logic [7:0] last_rd = 8'h00;
    logic       chk_valid = 1'b0;
    logic       in_rst    = 1'b0;
    logic       chk_rd    = 1'b0;
    logic       chk_ovf   = 1'b0;
    logic       chk_unf   = 1'b0;
    int         chk_cnt   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle on dut0: drive at negedge, update the model, hand the
    // expectations for this edge to the monitor.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic ra;
        logic wa;
        @(negedge clk);
        bus0.wr_en   = w;
        bus0.wr_data = d;
        bus0.rd_en   = r;
        ra = r && (m_q.size() != 0);
        wa = w && ((m_q.size() < 16) || ra);
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        @(posedge clk);
        chk_rd    = ra;
        chk_ovf   = w && !wa;
        chk_unf   = r && !ra;
        chk_cnt   = m_q.size();
        chk_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_valid && !in_rst) begin
            if (chk_rd) begin
                if (exp_q.size() == 0) begin
                    cmp("exp_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    last_rd = exp_q.pop_front();
                    cmp("rd_data", 32'(bus0.rd_data), 32'(last_rd));
                end
            end else begin
                cmp("rd_data_hold", 32'(bus0.rd_data), 32'(last_rd));
            end
            cmp("data_count",   32'(bus0.data_count),   32'(chk_cnt));
            cmp("full",         32'(bus0.full),         32'(chk_cnt == 16));
            cmp("empty",        32'(bus0.empty),        32'(chk_cnt == 0));
            cmp("almost_full",  32'(bus0.almost_full),  32'(chk_cnt >= 14));
            cmp("almost_empty", 32'(bus0.almost_empty), 32'(chk_cnt <= 2));
            cmp("overflow",     32'(bus0.overflow),     32'(chk_ovf));
            cmp("underflow",    32'(bus0.underflow),    32'(chk_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.wr_en = 1'b0; bus0.wr_data = 8'h00; bus0.rd_en = 1'b0;
        bus1.wr_en = 1'b0; bus1.wr_data = 8'h00; bus1.rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_empty",     32'(bus0.empty),        32'd1);
        cmp("rst_aempty",    32'(bus0.almost_empty), 32'd1);
        cmp("rst_full",      32'(bus0.full),         32'd0);
        cmp("rst_afull",     32'(bus0.almost_full),  32'd0);
        cmp("rst_count",     32'(bus0.data_count),   32'd0);
        cmp("rst_ovf",       32'(bus0.overflow),     32'd0);
        cmp("rst_unf",       32'(bus0.underflow),    32'd0);
        cmp("rst_rd_data",   32'(bus0.rd_data),      32'd0);
        cmp("rst_fwft_empty", 32'(bus1.empty),       32'd1);
        rst_n = 1'b1;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            #1;
            if (i == 12) cmp("afull_at_13", 32'(bus0.almost_full), 32'd0);
            if (i == 13) cmp("afull_at_14", 32'(bus0.almost_full), 32'd1);
        end
        cmp("fill_full",  32'(bus0.full),       32'd1);
        cmp("fill_count", 32'(bus0.data_count), 32'd16);

        // Overflow while full
        step(1'b1, 8'hAA, 1'b0);
        #1;
        cmp("ovf_pulse", 32'(bus0.overflow),   32'd1);
        cmp("ovf_count", 32'(bus0.data_count), 32'd16);
        step(1'b0, 8'h00, 1'b0);
        #1;
        cmp("ovf_drop",  32'(bus0.overflow),   32'd0);

        // Simultaneous access while full: 0x55 must come out last
        step(1'b1, 8'h55, 1'b1);
        #1;
        cmp("full_rw_count", 32'(bus0.data_count), 32'd16);
        cmp("full_rw_data",  32'(bus0.rd_data),    32'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        #1;
        cmp("drain_empty", 32'(bus0.empty),   32'd1);
        cmp("drain_last",  32'(bus0.rd_data), 32'h55);

        // Underflow while empty, then write+read on empty
        step(1'b0, 8'h00, 1'b1);
        #1;
        cmp("unf_pulse", 32'(bus0.underflow), 32'd1);
        cmp("unf_hold",  32'(bus0.rd_data),   32'h55);
        step(1'b1, 8'h77, 1'b1);
        #1;
        cmp("empty_rw_unf",   32'(bus0.underflow),  32'd1);
        cmp("empty_rw_count", 32'(bus0.data_count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        #1;
        cmp("empty_rw_data", 32'(bus0.rd_data), 32'h77);

        // Wrap-around at constant occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1);
        #1;
        cmp("wrap_count", 32'(bus0.data_count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        #1;
        cmp("wrap_last",  32'(bus0.rd_data), 32'hD7);
        cmp("wrap_empty", 32'(bus0.empty),   32'd1);

        // FWFT build
        @(negedge clk);
        bus1.wr_en = 1'b1; bus1.wr_data = 8'h12;
        @(negedge clk);
        cmp("fwft_first",   32'(bus1.rd_data), 32'h12);
        cmp("fwft_nempty",  32'(bus1.empty),   32'd0);
        bus1.wr_data = 8'h34;
        @(negedge clk);
        bus1.wr_en = 1'b0;
        cmp("fwft_head",  32'(bus1.rd_data),    32'h12);
        cmp("fwft_count", 32'(bus1.data_count), 32'd2);
        bus1.rd_en = 1'b1;
        @(negedge clk);
        bus1.rd_en = 1'b0;
        cmp("fwft_next",   32'(bus1.rd_data),    32'h34);
        cmp("fwft_count1", 32'(bus1.data_count), 32'd1);
        bus1.rd_en = 1'b1;
        @(negedge clk);
        bus1.rd_en = 1'b0;
        cmp("fwft_empty", 32'(bus1.empty), 32'd1);

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 10; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h4A, 1'b0);
        #3;
        in_rst = 1'b1;
        rst_n  = 1'b0;
        #1;
        cmp("mid_rst_empty", 32'(bus0.empty),      32'd1);
        cmp("mid_rst_count", 32'(bus0.data_count), 32'd0);
        cmp("mid_rst_data",  32'(bus0.rd_data),    32'd0);
        cmp("mid_rst_ovf",   32'(bus0.overflow),   32'd0);
        bus0.wr_en = 1'b0; bus0.wr_data = 8'h00; bus0.rd_en = 1'b0;
        #159;
        rst_n = 1'b1;
        m_q.delete();
        exp_q.delete();
        last_rd   = 8'h00;
        chk_valid = 1'b0;
        in_rst    = 1'b0;
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        #1;
        cmp("post_rst_data",  32'(bus0.rd_data), 32'hC3);
        cmp("post_rst_empty", 32'(bus0.empty),   32'd1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
